// File: rtl/alu_pkg.sv
// Shared definitions for the ALU, the issue stage and the execute/write-back stage:
// function encodings, instruction field positions and datapath widths.
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int RF_DEPTH = 8;
  localparam int REG_AW   = 3;
  localparam int IMM_W    = 7;

  localparam int FUNC_HI     = 15;
  localparam int FUNC_LO     = 14;
  localparam int IMM_SEL_BIT = 13;
  localparam int RD_HI       = 12;
  localparam int RD_LO       = 10;
  localparam int RS1_HI      = 9;
  localparam int RS1_LO      = 7;
  localparam int RS2_HI      = 6;
  localparam int RS2_LO      = 4;
  localparam int IMM_HI      = 6;
  localparam int IMM_LO      = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_SLT = 2'b11
  } alu_func_e;

endpackage

// File: rtl/issue_regfile.sv
// 8-entry architectural register file: r0 reads as zero, two combinational read
// ports that forward a same-cycle write-back, one synchronous write port.
module issue_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] mem [RF_DEPTH];
  logic              wb_live;

  assign wb_live = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
    end else if (wb_live) begin
      mem[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd1 = mem[rs1];
    if (rs1 == '0) rd1 = '0;
    else if (wb_live && (wb_addr == rs1)) rd1 = wb_data;
  end

  always_comb begin
    rd2 = mem[rs2];
    if (rs2 == '0) rd2 = '0;
    else if (wb_live && (wb_addr == rs2)) rd2 = wb_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 16-bit ALU: decode, operand read, RAW/WAW scoreboard
// and a single registered output bundle with valid/ready flow control.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_func,
  output logic [DATA_W-1:0]   out_src1,
  output logic [DATA_W-1:0]   out_src2,
  output logic [REG_AW-1:0]   out_rd,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [RF_DEPTH-1:0] busy_mask
);

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    logic signed [IMM_W-1:0] imm_s;
    imm_s = imm;
    return DATA_W'(imm_s);
  endfunction

  alu_func_e         func_p0;
  logic              imm_sel_p0;
  logic [REG_AW-1:0] rd_p0, rs1_p0, rs2_p0;
  logic [IMM_W-1:0]  imm_p0;
  logic [DATA_W-1:0] rd1_p0, rd2_p0, src2_p0;

  assign func_p0    = alu_func_e'(in_instr[FUNC_HI:FUNC_LO]);
  assign imm_sel_p0 = in_instr[IMM_SEL_BIT];
  assign rd_p0      = in_instr[RD_HI:RD_LO];
  assign rs1_p0     = in_instr[RS1_HI:RS1_LO];
  assign rs2_p0     = in_instr[RS2_HI:RS2_LO];
  assign imm_p0     = in_instr[IMM_HI:IMM_LO];

  issue_regfile u_rf (
    .clk     (clk),
    .rst     (rst),
    .rs1     (rs1_p0),
    .rs2     (rs2_p0),
    .rd1     (rd1_p0),
    .rd2     (rd2_p0),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  assign src2_p0 = imm_sel_p0 ? sext_imm(imm_p0) : rd2_p0;

  logic [RF_DEPTH-1:0] busy_p1, wb_clr, busy_eff, acc_set;
  logic                hazard, accept, vld_p1;

  always_comb begin
    wb_clr = '0;
    if (wb_en && (wb_addr != '0)) wb_clr[wb_addr] = 1'b1;
  end

  // A same-cycle write-back already retires its producer, so it cannot stall.
  assign busy_eff = busy_p1 & ~wb_clr;
  assign hazard   = busy_eff[rs1_p0] | (!imm_sel_p0 & busy_eff[rs2_p0]) | busy_eff[rd_p0];
  assign in_ready = !hazard && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_set = '0;
    if (accept && (rd_p0 != '0)) acc_set[rd_p0] = 1'b1;
  end

  alu_func_e         func_p1;
  logic [DATA_W-1:0] src1_p1, src2_p1;
  logic [REG_AW-1:0] rd_p1;

  // Stage boundary p0 -> p1: registered bundle and scoreboard (set wins over clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      func_p1 <= ALU_ADD;
      src1_p1 <= '0;
      src2_p1 <= '0;
      rd_p1   <= '0;
      busy_p1 <= '0;
    end else begin
      busy_p1 <= busy_eff | acc_set;
      if (accept) begin
        vld_p1  <= 1'b1;
        func_p1 <= func_p0;
        src1_p1 <= rd1_p0;
        src2_p1 <= src2_p0;
        rd_p1   <= rd_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_func  = func_p1;
  assign out_src1  = src1_p1;
  assign out_src2  = src2_p1;
  assign out_rd    = rd_p1;
  assign busy_mask = busy_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a register/pending-set reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_func;
  logic [15:0] out_src1, out_src2;
  logic [2:0]  out_rd;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic [7:0]  busy_mask;

  alu_issue_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_func  (out_func),
    .out_src1  (out_src1),
    .out_src2  (out_src2),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  func;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [2:0]  rd;
  } bundle_t;

  int          total = 0;
  int          bad = 0;
  bundle_t     q[$];
  logic [15:0] m_rf[8];
  bit          m_pend[8];
  bit          m_ov;
  bit          exp_ready;
  bundle_t     nb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int f, input int isel, input int rd,
                                      input int rs1, input int low7);
    logic [15:0] w;
    w = 16'((f & 3) << 14) | 16'((isel & 1) << 13) | 16'((rd & 7) << 10)
      | 16'((rs1 & 7) << 7) | 16'(low7 & 16'h7F);
    return w;
  endfunction

  function automatic logic [15:0] mread(input logic [2:0] a);
    if (a == 0) return 16'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit mbusy(input logic [2:0] a);
    return m_pend[a] && !(wb_en && wb_addr == a);
  endfunction

  function automatic logic [7:0] pend_mask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = m_pend[i];
    return m;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_rf[i] = 16'h0;
      m_pend[i] = 1'b0;
    end
    m_ov = 1'b0;
  endfunction

  // One clock: predict and check readiness before the edge, advance the model on it.
  task automatic cyc();
    logic [2:0] rd, rs1, rs2;
    bit isel, hz, acc;
    int tmp;
    #3;
    rd   = in_instr[12:10];
    rs1  = in_instr[9:7];
    rs2  = in_instr[6:4];
    isel = in_instr[13];
    hz   = mbusy(rs1) || (!isel && mbusy(rs2)) || mbusy(rd);
    exp_ready = !hz && (!m_ov || out_ready);
    chk("in_ready", in_ready, exp_ready);
    chk("busy_mask", busy_mask, pend_mask());
    nb.func = in_instr[15:14];
    nb.s1   = mread(rs1);
    tmp     = int'(in_instr[6:0]);
    if (tmp >= 64) tmp = tmp - 128;
    nb.s2   = isel ? 16'(tmp) : mread(rs2);
    nb.rd   = rd;
    @(posedge clk);
    acc = in_valid && exp_ready;
    if (wb_en && wb_addr != 0) begin
      m_rf[wb_addr] = wb_data;
      m_pend[wb_addr] = 1'b0;
    end
    if (acc) begin
      q.push_back(nb);
      if (nb.rd != 0) m_pend[nb.rd] = 1'b1;
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic do_wb(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1'b1;
    wb_addr = a;
    wb_data = d;
    cyc();
    wb_en = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int a = 1; a < 8; a++)
      if (m_pend[a]) do_wb(3'(a), 16'($urandom));
    cyc();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        chk("out_func", out_func, q[0].func);
        chk("out_src1", out_src1, q[0].s1);
        chk("out_src2", out_src2, q[0].s2);
        chk("out_rd", out_rd, q[0].rd);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    model_clear();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_src1", out_src1, 0);
    chk("rst_func", out_func, 0);

    // Basic register-register issue
    do_wb(3'd1, 16'h0005);
    do_wb(3'd2, 16'h0003);
    in_valid = 1'b1;
    in_instr = enc(0, 0, 3, 1, 2 << 4);
    cyc();
    in_valid = 1'b0;
    chk("t1_busy", busy_mask, 8'h08);
    chk("t1_src1", out_src1, 16'h0005);
    chk("t1_src2", out_src2, 16'h0003);

    // Immediates; the second one's rs2 field aliases busy r3
    in_valid = 1'b1;
    in_instr = enc(1, 1, 4, 1, 7'h7F);
    cyc();
    chk("t2_src2", out_src2, 16'hFFFF);
    in_instr = enc(0, 1, 6, 1, 7'h35);
    cyc();
    chk("t2_imm_issue", out_rd, 3'd6);
    drain();

    // RAW stall resolved by same-cycle write-back
    in_valid = 1'b1;
    in_instr = enc(0, 0, 3, 1, 2 << 4);
    cyc();
    in_instr = enc(2, 0, 5, 3, 1 << 4);
    repeat (3) cyc();
    chk("t3_stalled", in_ready, 0);
    wb_en = 1'b1;
    wb_addr = 3'd3;
    wb_data = 16'h0008;
    cyc();
    wb_en = 1'b0;
    in_valid = 1'b0;
    chk("t3_bypass_src1", out_src1, 16'h0008);
    drain();

    // Backpressure
    in_valid = 1'b1;
    in_instr = enc(0, 0, 6, 1, 2 << 4);
    cyc();
    out_ready = 1'b0;
    in_instr = enc(3, 0, 7, 2, 1 << 4);
    repeat (5) cyc();
    chk("t4_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t4_next_rd", out_rd, 3'd7);
    repeat (2) cyc();
    drain();

    // r0 is never busy and always reads zero
    in_valid = 1'b1;
    in_instr = enc(0, 0, 0, 0, 0);
    cyc();
    in_valid = 1'b0;
    chk("t5_busy", busy_mask, 0);
    do_wb(3'd0, 16'hBEEF);
    in_valid = 1'b1;
    in_instr = enc(0, 0, 1, 0, 0);
    cyc();
    in_valid = 1'b0;
    chk("t5_r0_read", out_src1, 0);
    drain();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_instr  = 16'($urandom);
      out_ready = ($urandom % 4) != 0;
      wb_en     = ($urandom % 3) == 0;
      wb_addr   = 3'($urandom);
      wb_data   = 16'($urandom);
      cyc();
    end
    wb_en = 1'b0;
    drain();

    // Asynchronous reset during a stall
    in_valid = 1'b1;
    in_instr = enc(0, 0, 3, 1, 2 << 4);
    cyc();
    in_instr = enc(0, 0, 5, 1, 2 << 4);
    cyc();
    out_ready = 1'b0;
    in_instr = enc(0, 0, 6, 1, 2 << 4);
    cyc();
    chk("t6_pre_busy", busy_mask, 8'h28);
    chk("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy_mask, 0);
    q.delete();
    model_clear();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_instr = enc(0, 0, 3, 1, 2 << 4);
    cyc();
    in_valid = 1'b0;
    chk("t6_rf_zeroed", out_src1, 0);
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
